// File: rtl/bram_byte_mem_if_if.sv
// Request/response bus between a load/store core (master) and bram_byte_mem_if (slave).
// Byte address width is ADDR_WIDTH word bits plus the in-word byte offset bits.
interface bram_byte_mem_if_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(NUM_BYTES);

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_write;
    logic [ADDR_WIDTH+OFF_W-1:0] req_addr;
    logic [1:0]                  req_size;
    logic                        req_signed;
    logic [DATA_WIDTH-1:0]       req_wdata;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [DATA_WIDTH-1:0]       resp_rdata;
    logic                        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_signed, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/bram_byte_mem_if.sv
// Byte-addressed load/store adapter in front of BRAM_byte_en with an in-order response buffer.
// Optional macro BRAM_IF_MISALIGN_CHECK_EN: misaligned or illegal-size accesses return resp_error.
module bram_byte_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    bram_byte_mem_if_if.slave       bus,
    output logic                    readEnable,
    output logic [ADDR_WIDTH-1:0]   readAddress,
    input  logic [DATA_WIDTH-1:0]   readData,
    output logic                    writeEnable,
    output logic [DATA_WIDTH/8-1:0] writeByteEnable,
    output logic [ADDR_WIDTH-1:0]   writeAddress,
    output logic [DATA_WIDTH-1:0]   writeData
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(NUM_BYTES);
    localparam int PTR_W     = $clog2(RESP_DEPTH);
    localparam int CNT_W     = $clog2(RESP_DEPTH + 1);
    localparam logic [1:0] MAX_SIZE = 2'(OFF_W);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : gBadWidth
            $error("bram_byte_mem_if: DATA_WIDTH must be 32 or 64");
        end
        if (RESP_DEPTH < 2) begin : gBadDepth
            $error("bram_byte_mem_if: RESP_DEPTH must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                 accept;
    logic [OFF_W-1:0]     reqOffset;
    logic [OFF_W-1:0]     alignOffset;
    logic [OFF_W-1:0]     sizeLowMask;
    logic [1:0]           effSize;
    logic                 misaligned;
    logic [NUM_BYTES-1:0] sizeByteMask;

    assign reqOffset    = bus.req_addr[OFF_W-1:0];
    // An illegal size (dword on a 32-bit port) is clamped to the full word for lane math.
    assign effSize      = (bus.req_size > MAX_SIZE) ? MAX_SIZE : bus.req_size;
    assign sizeLowMask  = OFF_W'((32'd1 << effSize) - 32'd1);
    assign alignOffset  = reqOffset & ~sizeLowMask;
    assign sizeByteMask = NUM_BYTES'((32'd1 << (32'd1 << effSize)) - 32'd1);

`ifdef BRAM_IF_MISALIGN_CHECK_EN
    assign misaligned = (bus.req_size > MAX_SIZE) || ((reqOffset & sizeLowMask) != '0);
`else
    assign misaligned = 1'b0;
`endif

    assign accept          = bus.req_valid && bus.req_ready;
    assign readEnable      = accept && !bus.req_write && !misaligned;
    assign writeEnable     = accept &&  bus.req_write && !misaligned;
    assign readAddress     = bus.req_addr[ADDR_WIDTH+OFF_W-1:OFF_W];
    assign writeAddress    = bus.req_addr[ADDR_WIDTH+OFF_W-1:OFF_W];
    assign writeByteEnable = sizeByteMask << alignOffset;

    // Each lane takes the store byte at (lane mod access size), replicating the datum.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : gLane
            assign writeData[gi*8 +: 8] = bus.req_wdata[8*(OFF_W'(gi) & sizeLowMask) +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // In-flight stage: lines up request attributes with BRAM readData
    // ------------------------------------------------------------------
    logic             flightValidReg;
    logic             flightWriteReg;
    logic [OFF_W-1:0] flightOffsetReg;
    logic [1:0]       flightSizeReg;
    logic             flightSignedReg;
    logic             flightErrorReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flightValidReg  <= 1'b0;
            flightWriteReg  <= 1'b0;
            flightOffsetReg <= '0;
            flightSizeReg   <= 2'd0;
            flightSignedReg <= 1'b0;
            flightErrorReg  <= 1'b0;
        end else begin
            flightValidReg <= accept;
            if (accept) begin
                flightWriteReg  <= bus.req_write;
                flightOffsetReg <= alignOffset;
                flightSizeReg   <= effSize;
                flightSignedReg <= bus.req_signed;
                flightErrorReg  <= misaligned;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] shiftedData;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] pushData;
    logic                  signBit;
    logic                  signFill;
    int                    loadWidthBits;

    assign shiftedData   = readData >> {flightOffsetReg, 3'b000};
    assign loadWidthBits = 8 << flightSizeReg;

    always_comb begin
        signBit = 1'b0;
        case (flightSizeReg)
            2'd0:    signBit = shiftedData[7];
            2'd1:    signBit = shiftedData[15];
            2'd2:    signBit = shiftedData[31];
            default: signBit = shiftedData[DATA_WIDTH-1];
        endcase
    end

    assign signFill = flightSignedReg && signBit;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : gExtend
            assign loadData[gi] = (gi < loadWidthBits) ? shiftedData[gi] : signFill;
        end
    endgenerate

    assign pushData = (flightWriteReg || flightErrorReg) ? '0 : loadData;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] respDataMem  [RESP_DEPTH];
    logic                  respErrorMem [RESP_DEPTH];
    logic [PTR_W-1:0]      wrPtrReg;
    logic [PTR_W-1:0]      rdPtrReg;
    logic [CNT_W-1:0]      countReg;
    logic [CNT_W-1:0]      countNext;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        committed;

    function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign push = flightValidReg;
    assign pop  = bus.resp_valid && bus.resp_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            respDataMem[wrPtrReg]  <= pushData;
            respErrorMem[wrPtrReg] <= flightErrorReg;
        end
    end

    always_comb begin
        countNext = countReg;
        if (push && !pop) begin
            countNext = countReg + CNT_W'(1);
        end else if (!push && pop) begin
            countNext = countReg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (push) begin
                wrPtrReg <= wrapInc(wrPtrReg);
            end
            if (pop) begin
                rdPtrReg <= wrapInc(rdPtrReg);
            end
            countReg <= countNext;
        end
    end

    // Head is masked while empty so stale entries never reach the core.
    assign bus.resp_valid = (countReg != '0);
    assign bus.resp_rdata = bus.resp_valid ? respDataMem[rdPtrReg] : '0;
    assign bus.resp_error = bus.resp_valid && respErrorMem[rdPtrReg];

    // A slot must be reserved for the entry in flight; a same-cycle pop frees one.
    assign committed     = {1'b0, countReg} + (CNT_W+1)'(flightValidReg) - (CNT_W+1)'(pop);
    assign bus.req_ready = reset && (committed < (CNT_W+1)'(RESP_DEPTH));

endmodule

// File: tb/tb_bram_byte_mem_if.sv
// Self-checking bench for bram_byte_mem_if with a behavioural BRAM_byte_en model and a
// response scoreboard; expected loads come from a byte-addressed reference memory.
module tb_bram_byte_mem_if;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int RESP_DEPTH = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } respT;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bram_byte_mem_if_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    logic                  readEnable;
    logic [ADDR_WIDTH-1:0] readAddress;
    logic [DATA_WIDTH-1:0] readData;
    logic                  writeEnable;
    logic [3:0]            writeByteEnable;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0] writeData;

    bram_byte_mem_if #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .readEnable     (readEnable),
        .readAddress    (readAddress),
        .readData       (readData),
        .writeEnable    (writeEnable),
        .writeByteEnable(writeByteEnable),
        .writeAddress   (writeAddress),
        .writeData      (writeData)
    );

    // Behavioural BRAM_byte_en: byte-enabled write, one-cycle registered read.
    logic [31:0] bramMem [256];
    bit          bramInit = 1'b0;
    always @(posedge clock) begin
        if (!bramInit) begin
            for (int i = 0; i < 256; i++) bramMem[i] = 32'h0;
            bramMem[2] = 32'hAAAA8888;
            bramInit = 1'b1;
        end
        if (writeEnable) begin
            for (int b = 0; b < 4; b++) begin
                if (writeByteEnable[b]) bramMem[writeAddress][8*b +: 8] = writeData[8*b +: 8];
            end
        end
        if (readEnable) readData <= bramMem[readAddress];
    end

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Response ready driver: fixed level or random back-pressure.
    bit fixedReady  = 1'b1;
    bit randomReady = 1'b0;
    always @(posedge clock) begin
        #1;
        bus.resp_ready = randomReady ? ($urandom_range(0, 3) != 0) : fixedReady;
    end

    // Scoreboard and response monitor
    respT expQ[$];
    respT expEntry;
    int   popCount  = 0;
    int   cycleCount = 0;
    int   popCycles[$];

    always @(posedge clock) cycleCount++;

    always @(negedge clock) begin
        if (reset && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            checkValue($sformatf("resp%0d_expected", popCount), 64'(expQ.size() != 0), 64'(1));
            if (expQ.size() != 0) begin
                expEntry = expQ.pop_front();
                $display("resp %0d: rdata=0x%08h error=%0b (expect 0x%08h/%0b)",
                         popCount, bus.resp_rdata, bus.resp_error, expEntry.data, expEntry.err);
                checkValue($sformatf("resp%0d_rdata", popCount), 64'(bus.resp_rdata), 64'(expEntry.data));
                checkValue($sformatf("resp%0d_error", popCount), 64'(bus.resp_error), 64'(expEntry.err));
            end
            popCycles.push_back(cycleCount);
            popCount++;
        end
    end

    // Byte-addressed reference memory
    logic [7:0] refBytes [1024];

    task automatic modelStore(input int addr, input int size, input logic [31:0] wdata);
        for (int k = 0; k < (1 << size); k++) refBytes[addr + k] = wdata[8*k +: 8];
    endtask

    function automatic logic [31:0] modelLoad(input int addr, input int size, input bit sgn);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = 1 << size;
        for (int k = 0; k < n; k++) v[8*k +: 8] = refBytes[addr + k];
        if (sgn && n < 4 && v[8*n-1]) begin
            for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    logic                  lastRe;
    logic [ADDR_WIDTH-1:0] lastRa;
    logic                  lastWe;
    logic [3:0]            lastWbe;
    logic [31:0]           lastWdata;
    int                    lastWaits;

    task automatic sendReq(input logic wr, input logic [9:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata,
                           input logic [31:0] expData, input logic expErr);
        int  waits;
        bit  done;
        respT e;
        waits = 0;
        done  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
        while (!done) begin
            @(negedge clock);
            if (bus.req_ready === 1'b1) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits >= 200) begin
                    checkValue("req_ready_timeout", 64'(bus.req_ready), 64'(1));
                    bus.req_valid = 1'b0;
                    return;
                end
            end
        end
        lastRe    = readEnable;
        lastRa    = readAddress;
        lastWe    = writeEnable;
        lastWbe   = writeByteEnable;
        lastWdata = writeData;
        lastWaits = waits;
        e.data = expData;
        e.err  = expErr;
        expQ.push_back(e);
        $display("req: %s addr=0x%03h size=%0d signed=%0b wdata=0x%08h waits=%0d",
                 wr ? "store" : "load ", addr, size, sgn, wdata, waits);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 300 && expQ.size() != 0; c++) @(posedge clock);
        checkValue(tag, 64'(expQ.size()), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int   popBefore;
    int   spacing;
    int   sz;
    int   addrI;
    bit   wrB;
    bit   sgB;
    logic [31:0] wd;
    logic [31:0] exp6;
    logic        err6;
    logic        re6;

    initial begin
        for (int i = 0; i < 1024; i++) refBytes[i] = 8'h00;
        modelStore(8, 2, 32'hAAAA8888);

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = '0;

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkValue("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        checkValue("rst_req_ready",  64'(bus.req_ready),  64'(0));
        checkValue("rst_resp_rdata", 64'(bus.resp_rdata), 64'(0));
        checkValue("rst_resp_error", 64'(bus.resp_error), 64'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checkValue("rel_req_ready", 64'(bus.req_ready), 64'(1));
        @(posedge clock);
        #1;

        // 1: word load, one-cycle latency
        sendReq(1'b0, 10'h008, 2'd2, 1'b0, 32'h0, 32'hAAAA8888, 1'b0);
        idle();
        checkValue("t1_readEnable",  64'(lastRe), 64'(1));
        checkValue("t1_readAddress", 64'(lastRa), 64'(2));
        @(negedge clock);
        checkValue("t1_resp_not_yet", 64'(bus.resp_valid), 64'(0));
        @(negedge clock);
        checkValue("t1_resp_valid", 64'(bus.resp_valid), 64'(1));
        drain("t1_drain");

        // 2: byte store into lane 2
        @(posedge clock);
        #1;
        modelStore(10, 0, 32'h000000CC);
        sendReq(1'b1, 10'h00A, 2'd0, 1'b0, 32'h000000CC, 32'h0, 1'b0);
        idle();
        checkValue("t2_writeEnable",     64'(lastWe),    64'(1));
        checkValue("t2_readEnable",      64'(lastRe),    64'(0));
        checkValue("t2_writeByteEnable", 64'(lastWbe),   64'(4'b0100));
        checkValue("t2_writeData",       64'(lastWdata), 64'(32'hCCCCCCCC));
        drain("t2_drain");
        checkValue("t2_bram_word2", 64'(bramMem[2]), 64'(32'hAACC8888));

        // 3: back-to-back loads, one response per cycle
        @(posedge clock);
        #1;
        sendReq(1'b0, 10'h00A, 2'd1, 1'b1, 32'h0, 32'hFFFFAACC, 1'b0);
        checkValue("t3_wait0", 64'(lastWaits), 64'(0));
        sendReq(1'b0, 10'h00A, 2'd1, 1'b0, 32'h0, 32'h0000AACC, 1'b0);
        checkValue("t3_wait1", 64'(lastWaits), 64'(0));
        sendReq(1'b0, 10'h008, 2'd0, 1'b1, 32'h0, 32'hFFFFFF88, 1'b0);
        checkValue("t3_wait2", 64'(lastWaits), 64'(0));
        idle();
        drain("t3_drain");
        spacing = (popCycles.size() >= 3) ?
                  popCycles[popCycles.size()-1] - popCycles[popCycles.size()-3] : -1;
        checkValue("t3_pop_spacing", 64'(spacing), 64'(2));

        // 6: misaligned half load
`ifdef BRAM_IF_MISALIGN_CHECK_EN
        exp6 = 32'h0;
        err6 = 1'b1;
        re6  = 1'b0;
`else
        exp6 = 32'hFFFF8888;
        err6 = 1'b0;
        re6  = 1'b1;
`endif
        @(posedge clock);
        #1;
        sendReq(1'b0, 10'h009, 2'd1, 1'b1, 32'h0, exp6, err6);
        idle();
        checkValue("t6_readEnable", 64'(lastRe), 64'(re6));
        drain("t6_drain");

        // 4: back-pressure fills the buffer, nothing lost
        fixedReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        popBefore = popCount;
        sendReq(1'b0, 10'h008, 2'd2, 1'b0, 32'h0, 32'hAACC8888, 1'b0);
        sendReq(1'b0, 10'h00A, 2'd0, 1'b0, 32'h0, 32'h000000CC, 1'b0);
        checkValue("t4_second_waits", 64'(lastWaits), 64'(0));
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 10'h00B;
        bus.req_size  = 2'd0;
        @(negedge clock);
        checkValue("t4_full_req_ready",  64'(bus.req_ready), 64'(0));
        checkValue("t4_full_readEnable", 64'(readEnable),    64'(0));
        repeat (3) @(negedge clock);
        checkValue("t4_hold_req_ready",  64'(bus.req_ready),  64'(0));
        checkValue("t4_hold_resp_valid", 64'(bus.resp_valid), 64'(1));
        checkValue("t4_no_pop",          64'(popCount),       64'(popBefore));
        @(posedge clock);
        #1 fixedReady = 1'b1;
        sendReq(1'b0, 10'h00B, 2'd0, 1'b1, 32'h0, 32'hFFFFFFAA, 1'b0);
        idle();
        drain("t4_drain");
        checkValue("t4_pop_count", 64'(popCount - popBefore), 64'(3));

        // 5: reset with one in flight and one buffered
        fixedReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        popBefore = popCount;
        sendReq(1'b0, 10'h008, 2'd2, 1'b0, 32'h0, 32'hAACC8888, 1'b0);
        sendReq(1'b0, 10'h008, 2'd2, 1'b0, 32'h0, 32'hAACC8888, 1'b0);
        reset = 1'b0;
        idle();
        #1;
        checkValue("t5_rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        checkValue("t5_rst_req_ready",  64'(bus.req_ready),  64'(0));
        checkValue("t5_rst_resp_rdata", 64'(bus.resp_rdata), 64'(0));
        expQ.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        fixedReady = 1'b1;
        @(negedge clock);
        checkValue("t5_rel_req_ready", 64'(bus.req_ready), 64'(1));
        repeat (6) @(posedge clock);
        checkValue("t5_no_stale", 64'(popCount), 64'(popBefore));
        #1;

        // Random aligned traffic under random back-pressure
        randomReady = 1'b1;
        for (int n = 0; n < 40; n++) begin
            sz    = $urandom_range(0, 2);
            addrI = $urandom_range(0, 63) & ~((1 << sz) - 1);
            wrB   = 1'($urandom_range(0, 1));
            sgB   = 1'($urandom_range(0, 1));
            wd    = $urandom();
            if (wrB) begin
                modelStore(addrI, sz, wd);
                sendReq(1'b1, 10'(addrI), 2'(sz), sgB, wd, 32'h0, 1'b0);
            end else begin
                sendReq(1'b0, 10'(addrI), 2'(sz), sgB, wd, modelLoad(addrI, sz, sgB), 1'b0);
            end
        end
        idle();
        randomReady = 1'b0;
        drain("rand_drain");

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
